// File: rtl/whistle_sequencer.sv
// Shares one whistle/amplifier path between four game-event requesters:
// latches requests, grants by fixed priority, wakes the amp, fires the start pulse, then holds for play + gap.
module whistle_sequencer #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TICK_FREQ  = 1_000,
    parameter int WAKE_TICKS = 5,
    parameter int GAP_TICKS  = 100,
    parameter int DUR0       = 300,
    parameter int DUR1       = 600,
    parameter int DUR2       = 1000,
    parameter int DUR3       = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic       whistle_start,
    output logic [1:0] sound_id,
    output logic       busy,
    output logic       shut_down_n,
    output logic       gain,
    output logic [3:0] pending
);

    localparam int DIV = CLK_FREQ / TICK_FREQ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // A zero-length phase would never see its final tick, so clamp to one.
    function automatic logic [31:0] ticks_of(input int n);
        return (n < 1) ? 32'd1 : 32'(n);
    endfunction

    localparam logic [31:0] WAKE_N = ticks_of(WAKE_TICKS);
    localparam logic [31:0] GAP_N  = ticks_of(GAP_TICKS);
    localparam logic [31:0] DUR0_N = ticks_of(DUR0);
    localparam logic [31:0] DUR1_N = ticks_of(DUR1);
    localparam logic [31:0] DUR2_N = ticks_of(DUR2);
    localparam logic [31:0] DUR3_N = ticks_of(DUR3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_START,
        S_PLAY,
        S_GAP
    } state_t;

    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic [31:0]   tick_cnt_reg;
    logic [3:0]    pend_reg;
    logic [3:0]    pend_next;
    logic [3:0]    ack_reg;
    logic          start_reg;
    logic [1:0]    sound_id_reg;
    logic          busy_reg;
    logic          shut_down_n_reg;
    logic          gain_reg;

    logic [3:0]    grant_onehot;
    logic [3:0]    grant_clr;
    logic [1:0]    grant_id;
    logic [31:0]   dur_sel;
    logic [31:0]   phase_len;
    logic          tick;
    logic          phase_done;
    logic          timed_state;

    assign grant_onehot = pend_reg & (~pend_reg + 4'd1);
    assign grant_clr    = (state_reg == S_IDLE) ? grant_onehot : 4'd0;

    always_comb begin
        grant_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_reg[i]) grant_id = 2'(i);
        end
    end

    // A request arriving on the grant cycle survives the clear: set wins.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            assign pend_next[gi] = req[gi] | (pend_reg[gi] & ~grant_clr[gi]);
        end
    endgenerate

    always_comb begin
        case (sound_id_reg)
            2'd0:    dur_sel = DUR0_N;
            2'd1:    dur_sel = DUR1_N;
            2'd2:    dur_sel = DUR2_N;
            default: dur_sel = DUR3_N;
        endcase
    end

    always_comb begin
        case (state_reg)
            S_WAKE:  phase_len = WAKE_N;
            S_PLAY:  phase_len = dur_sel;
            S_GAP:   phase_len = GAP_N;
            default: phase_len = 32'd1;
        endcase
    end

    assign tick        = (presc_reg == PRESC_LAST);
    assign phase_done  = tick && (tick_cnt_reg == phase_len - 32'd1);
    assign timed_state = (state_reg == S_WAKE) || (state_reg == S_PLAY) || (state_reg == S_GAP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            presc_reg       <= '0;
            tick_cnt_reg    <= '0;
            pend_reg        <= '0;
            ack_reg         <= '0;
            start_reg       <= 1'b0;
            sound_id_reg    <= '0;
            busy_reg        <= 1'b0;
            shut_down_n_reg <= 1'b0;
            gain_reg        <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            ack_reg   <= '0;
            start_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (|pend_reg) begin
                        state_reg       <= S_WAKE;
                        sound_id_reg    <= grant_id;
                        ack_reg         <= grant_onehot;
                        busy_reg        <= 1'b1;
                        shut_down_n_reg <= 1'b1;
                        gain_reg        <= grant_id[1];
                    end
                end
                S_WAKE: begin
                    if (phase_done) begin
                        state_reg <= S_START;
                        start_reg <= 1'b1;
                    end
                end
                S_START: state_reg <= S_PLAY;
                S_PLAY: begin
                    if (phase_done) begin
                        state_reg       <= S_GAP;
                        shut_down_n_reg <= 1'b0;
                        gain_reg        <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (phase_done) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // Counters run only inside timed phases and restart on every phase entry.
            if (timed_state && !phase_done) begin
                if (tick) begin
                    presc_reg    <= '0;
                    tick_cnt_reg <= tick_cnt_reg + 32'd1;
                end else begin
                    presc_reg <= presc_reg + PW'(1);
                end
            end else begin
                presc_reg    <= '0;
                tick_cnt_reg <= '0;
            end
        end
    end

    assign ack           = ack_reg;
    assign whistle_start = start_reg;
    assign sound_id      = sound_id_reg;
    assign busy          = busy_reg;
    assign shut_down_n   = shut_down_n_reg;
    assign gain          = gain_reg;
    assign pending       = pend_reg;

endmodule

// File: tb/tb_whistle_sequencer.sv
// Scoreboard bench for whistle_sequencer: a timestamp-level model predicts grants/starts and per-cycle flags;
// a negedge monitor compares DUT outputs against it.
module tb_whistle_sequencer;

    localparam int DIV = 10;
    localparam int W   = 2 * DIV;
    localparam int G   = 3 * DIV;
    int dur_t [4] = '{1, 2, 3, 4};

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic       whistle_start;
    logic [1:0] sound_id;
    logic       busy;
    logic       shut_down_n;
    logic       gain;
    logic [3:0] pending;

    whistle_sequencer #(
        .CLK_FREQ   (1000),
        .TICK_FREQ  (100),
        .WAKE_TICKS (2),
        .GAP_TICKS  (3),
        .DUR0       (1),
        .DUR1       (2),
        .DUR2       (3),
        .DUR3       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .ack           (ack),
        .whistle_start (whistle_start),
        .sound_id      (sound_id),
        .busy          (busy),
        .shut_down_n   (shut_down_n),
        .gain          (gain),
        .pending       (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int id;
        int t;
    } exp_t;

    exp_t ack_q[$];
    exp_t start_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_seen = 0;
    bit mon_en = 1'b0;

    // Model state: pending set, when the path is next free, and the current sound's timeline.
    logic [3:0] pend_m = '0;
    int free_at = 0;
    bit active = 1'b0;
    int g_cur = 0;
    int d_cur = 0;
    int sid_m = 0;
    bit busy_m = 1'b0;
    bit sdn_m = 1'b0;
    bit gain_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int id;
        cyc++;
        if (!rst) begin
            pend_m  = '0;
            active  = 1'b0;
            sid_m   = 0;
            free_at = cyc + 1;
            ack_q.delete();
            start_q.delete();
        end else begin
            if (cyc >= free_at && pend_m != 4'd0) begin
                id = 0;
                for (int i = 3; i >= 0; i--) if (pend_m[i]) id = i;
                g_cur   = cyc;
                d_cur   = dur_t[id] * DIV;
                active  = 1'b1;
                sid_m   = id;
                free_at = cyc + W + d_cur + G + 2;
                pend_m[id] = 1'b0;
                ack_q.push_back('{id, cyc});
                start_q.push_back('{id, cyc + W});
            end
            pend_m = pend_m | req;
        end
        busy_m = active && (cyc >= g_cur) && (cyc <= g_cur + W + d_cur + G);
        sdn_m  = active && (cyc >= g_cur) && (cyc <= g_cur + W + d_cur);
        gain_m = sdn_m && (sid_m >= 2);
    end

    always @(negedge clk) begin
        logic [3:0] exp_ack;
        logic       exp_start;
        if (mon_en) begin
            exp_ack = 4'd0;
            if (ack_q.size() > 0 && ack_q[0].t == cyc) begin
                exp_ack = 4'd1 << ack_q[0].id;
                $display("txn grant id=%0d cycle=%0d ack=%b", ack_q[0].id, cyc, ack);
                void'(ack_q.pop_front());
            end
            chk("ack", 32'(ack), 32'(exp_ack));

            exp_start = 1'b0;
            if (start_q.size() > 0 && start_q[0].t == cyc) begin
                exp_start = 1'b1;
                $display("txn start id=%0d cycle=%0d whistle_start=%b", start_q[0].id, cyc, whistle_start);
                void'(start_q.pop_front());
            end
            chk("whistle_start", 32'(whistle_start), 32'(exp_start));
            if (whistle_start === 1'b1) start_seen++;

            chk("sound_id", 32'(sound_id), 32'(sid_m));
            chk("busy", 32'(busy), 32'(busy_m));
            chk("shut_down_n", 32'(shut_down_n), 32'(sdn_m));
            chk("gain", 32'(gain), 32'(gain_m));
            chk("pending", 32'(pending), 32'(pend_m));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] v, input int n);
        req = v;
        cycles(n);
        req = 4'd0;
    endtask

    initial begin
        int s0;
        logic [3:0] r;
        rst = 1'b0;
        req = 4'd0;
        cycles(3);
        mon_en = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(3);

        // single request
        s0 = start_seen;
        pulse(4'b0001, 1);
        cycles(250);
        chk("single_starts", 32'(start_seen - s0), 32'd1);

        // simultaneous 1 and 3
        s0 = start_seen;
        pulse(4'b1010, 1);
        cycles(250);
        chk("simul_starts", 32'(start_seen - s0), 32'd2);

        // re-request during play
        s0 = start_seen;
        pulse(4'b0100, 1);
        cycles(30);
        pulse(4'b0100, 1);
        cycles(250);
        chk("rereq_starts", 32'(start_seen - s0), 32'd2);

        // reset during play of sound 3
        s0 = start_seen;
        pulse(4'b1000, 1);
        cycles(34);
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(250);
        chk("reset_starts", 32'(start_seen - s0), 32'd1);

        // no preemption: sound 0 waits for sound 3
        s0 = start_seen;
        pulse(4'b1000, 1);
        cycles(30);
        pulse(4'b0001, 1);
        cycles(250);
        chk("nopreempt_starts", 32'(start_seen - s0), 32'd2);

        // held request collapses to two plays
        s0 = start_seen;
        pulse(4'b0001, 5);
        cycles(250);
        chk("burst_starts", 32'(start_seen - s0), 32'd2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 39) == 0);
            req = r;
            cycles(1);
        end
        req = 4'd0;
        cycles(700);

        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("start_queue_drained", 32'(start_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/whistle_sequencer.md
Name: whistle_sequencer

Overview:
- Arbitrates and sequences shared use of the single whistle/audio path between 4 game-event requesters (e.g. serve, point, set end, match end).
- Latches pending requests, grants one at a time by fixed priority, and powers the amplifier up with a wake delay.
- Fires the single-cycle start pulse into the whistle volume envelope, then holds the path for a per-sound duration plus a silence gap.
- Sits between game logic and the whistle block; drives its start input and amplifier shutdown/gain pins.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- TICK_FREQ, 1_000, timebase tick frequency in Hz. DIV = CLK_FREQ/TICK_FREQ clocks per tick; DIV must be at least 2.
- WAKE_TICKS, 5, amplifier wake delay in ticks before start.
- GAP_TICKS, 100, mandatory silence between sounds, in ticks.
- DUR0, 300, play duration of sound 0, in ticks.
- DUR1, 600, play duration of sound 1, in ticks.
- DUR2, 1000, play duration of sound 2, in ticks.
- DUR3, 2000, play duration of sound 3, in ticks.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-low reset.
- req, in, 4: request strobes; any cycle with req[i]=1 registers a request for sound i.
- ack, out, 4: one-cycle pulse on the bit of the request granted.
- whistle_start, out, 1: one-cycle pulse to the whistle start input.
- sound_id, out, 2: id of the sound currently owning the path.
- busy, out, 1: high in every state except IDLE.
- shut_down_n, out, 1: amplifier enable; high in WAKE, START and PLAY.
- gain, out, 1: amplifier gain select; 1 for sound ids 2 and 3, 0 for ids 0 and 1.
- pending, out, 4: current pending-request flags.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State becomes IDLE.
  - pending, ack, whistle_start, sound_id, busy, shut_down_n and gain all clear to 0.
  - Prescaler and tick counter clear to 0.
  - req is ignored while rst=0.
  - Reset mid-sound aborts immediately; no start pulse or ack is emitted afterwards.
- Pending flags:
  - pend[i] is set on any cycle req[i]=1.
  - pend[i] is cleared on the cycle sound i is granted.
  - If set and clear coincide for the same bit, set wins: the request is served again later.
  - Repeated req for an already-pending id collapses into one request.
- Arbitration:
  - Happens only in IDLE, evaluated on the registered pend.
  - Lowest index wins.
  - No preemption: requests arriving during WAKE, PLAY or GAP wait.
- Timebase:
  - A prescaler counts 0..DIV-1 and emits a tick when it wraps.
  - Prescaler and tick counter both restart at 0 on every state entry.
  - A state of N ticks therefore lasts exactly N*DIV clocks.
  - A duration parameter of 0 is treated as 1.
- States:
  - IDLE:
    - If pend != 0: go to WAKE.
    - In that same transition cycle: latch sound_id, register ack[id]=1 (visible next cycle), clear pend[id].
  - WAKE:
    - Outputs: shut_down_n=1, busy=1, gain per id.
    - Lasts WAKE_TICKS*DIV clocks, then go to START.
  - START:
    - Exactly 1 clock with whistle_start=1, then go to PLAY.
  - PLAY:
    - Lasts DUR[sound_id]*DIV clocks, then go to GAP.
  - GAP:
    - Outputs: shut_down_n=0, busy=1.
    - Lasts GAP_TICKS*DIV clocks, then go to IDLE.
- Latency and cadence:
  - From req[i] high at edge k with idle path: pend visible after k; IDLE exits at k+1; ack high at k+2.
  - whistle_start is high at k+2+WAKE_TICKS*DIV.
  - The next grant can occur on the first IDLE cycle after GAP, so back-to-back service is continuous.
- sound_id holds its value through GAP and IDLE until the next grant.
- All outputs are registered.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1000, TICK_FREQ=100 (DIV=10), WAKE_TICKS=2, GAP_TICKS=3, DUR0..DUR3 = 1, 2, 3, 4.
- Single request: req=0001 for 1 cycle at edge 0 -> ack=0001 at edge 2; shut_down_n rises at edge 2; whistle_start high only at edge 22; busy falls at edge 23+10+30 = 63.
- Simultaneous: req=1010 for 1 cycle -> sound 1 granted first (ack=0010); pending=1000 throughout; sound 3 acked on the first IDLE cycle after the gap; gain=1 during sound 3 only.
- Re-request during play: req=0100, then req=0100 again during PLAY -> sound 2 played twice; exactly two whistle_start pulses; PLAY duration 30 clocks each.
- Reset mid-PLAY: assert rst=0 during PLAY of sound 3 -> next edge has all outputs 0 and pending=0000; no further whistle_start.
- Priority and no preemption: sound 3 in PLAY, then req=0001 -> sound 3 completes all 40 PLAY clocks; sound 0 granted only after GAP.
- Burst collapse: req=0001 held high for 5 cycles while IDLE -> first pulse granted; overlap with the grant cycle re-sets pend[0]; sound 0 therefore plays twice, never three times.
